bram_arbiter: RTL

Two-requester arbiter for the single-port 16×16 block RAM used by the memory write/read experiments. It accepts independent read/write requests from two clients with a req/gnt handshake and round-robin priority. It drives the BRAM `ena`/`wea`/`addra`/`dina` port and routes returned `douta` read data back to the issuing client with a `rvalid` pulse. It sits between the BRAM IP and the client sequencers: a pattern writer and an LED readback unit.

---
 rtl/bram_arbiter_pkg.sv | 30 +++
 rtl/bram_arbiter_rd_tag_pipe.sv | 45 ++++
 rtl/bram_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_arbiter_pkg
//  Description : Shared types and constants for the two-client BRAM arbiter.
//                This covers the BRAM geometry, the client id and the read
//                tag carried alongside each in-flight read.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_arbiter_pkg;

    // Geometry of the 16x16 single-port block RAM
    localparam int BRAM_AW = 4;
    localparam int BRAM_DW = 16;

    // Which client issued an access
    typedef logic client_id_t;

    localparam client_id_t c_client0 = 1'b0;
    localparam client_id_t c_client1 = 1'b1;

    // Tag travelling with each BRAM access so read data can be routed back
    typedef struct packed {
        logic       valid;
        client_id_t id;
    } rd_tag_t;

    localparam rd_tag_t c_tag_idle = '{valid: 1'b0, id: c_client0};

endpackage : bram_arbiter_pkg
`default_nettype wire

// File: rtl/bram_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : bram_arbiter_rd_tag_pipe
//  Description : Fixed-depth shift register of read tags. One tag enters
//                every cycle and one leaves every cycle, so the tag reaching
//                the tail lines up with the BRAM data for that access.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter_rd_tag_pipe
    import bram_arbiter_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clka,
    input  logic    rst,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [DEPTH];

    // Head stage takes the new tag and clears to idle on reset
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_stage[0] <= c_tag_idle;
        end else begin
            r_stage[0] <= i_tag;
        end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        // Each later stage copies its predecessor, so in-flight reads vanish on reset
        always_ff @(posedge clka or posedge rst) begin
            if (rst) begin
                r_stage[g] <= c_tag_idle;
            end else begin
                r_stage[g] <= r_stage[g-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule : bram_arbiter_rd_tag_pipe
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_arbiter
//  Description : Round-robin arbiter that lets two clients share a single-port
//                block RAM. Grants are combinational and the BRAM port is
//                registered. Read data is steered back to the issuing client
//                using a tag pipeline that matches the BRAM read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int AW     = BRAM_AW,
    parameter int DW     = BRAM_DW,
    parameter int RD_LAT = 2
) (
    input  logic          clka,
    input  logic          rst,
    // client 0
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    // client 1
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    // BRAM port
    output logic          ena,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] dina,
    input  logic [DW-1:0] douta
);

    // The tag must leave the pipe in the same cycle douta becomes valid:
    // one cycle for the issue register plus RD_LAT cycles inside the BRAM.
    localparam int c_pipe_depth = RD_LAT + 1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_grant;
    client_id_t    w_gnt_id;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    rd_tag_t       w_tag_in;
    rd_tag_t       w_tag_out;

    client_id_t    r_prio;
    logic          r_ena;
    logic          r_wea;
    logic [AW-1:0] r_addra;
    logic [DW-1:0] r_dina;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    // Grant decision: a lone requester wins, and a tie goes to the priority
    // pointer. Reset masks the grant so no request is consumed while held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                w_gnt0 = (r_prio == c_client0);
                w_gnt1 = (r_prio == c_client1);
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    assign w_grant  = w_gnt0 | w_gnt1;
    assign w_gnt_id = w_gnt1 ? c_client1 : c_client0;

    // Route the winning client's request fields toward the issue registers
    always_comb begin
        w_sel_we    = we0;
        w_sel_addr  = addr0;
        w_sel_wdata = wdata0;
        if (w_gnt_id == c_client1) begin
            w_sel_we    = we1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end
    end

    // Priority pointer moves to the other client after every grant
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_prio <= c_client0;
        end else if (w_grant) begin
            r_prio <= client_id_t'(~w_gnt_id);
        end
    end

    // Issue registers driving the BRAM port. Address and data hold when idle.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_ena   <= 1'b0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
        end else begin
            r_ena <= w_grant;
            r_wea <= w_grant & w_sel_we;
            if (w_grant) begin
                r_addra <= w_sel_addr;
                r_dina  <= w_sel_wdata;
            end
        end
    end

    // Only reads need a response, so writes and idle cycles enter as bubbles
    assign w_tag_in = '{valid: w_grant & ~w_sel_we, id: w_gnt_id};

    bram_arbiter_rd_tag_pipe #(
        .DEPTH (c_pipe_depth)
    ) u_rd_tag_pipe (
        .clka  (clka),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    // Capture douta for the client named by the tail tag and pulse its rvalid
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_tag_out.valid && (w_tag_out.id == c_client0);
            r_rvalid1 <= w_tag_out.valid && (w_tag_out.id == c_client1);
            if (w_tag_out.valid && (w_tag_out.id == c_client0)) begin
                r_rdata0 <= douta;
            end
            if (w_tag_out.valid && (w_tag_out.id == c_client1)) begin
                r_rdata1 <= douta;
            end
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign ena     = r_ena;
    assign wea     = r_wea;
    assign addra   = r_addra;
    assign dina    = r_dina;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule : bram_arbiter
`default_nettype wire
